uart_tx_fifo_drain: RTL and testbench

- UART transmitter that drains the byte-wide read side of the interleaved TX FIFO and serialises each byte onto the TX line as 8N1 (or 8E1 with the optional parity feature).
- Sits between the FIFO read port and the pad.
- Pulses `ack` once per byte consumed; this is the same single-cycle ack the FIFO uses to advance its read pointer.

---
 rtl/uart_tx_fifo_drain_pkg.sv | 21 ++
 rtl/uart_tx_fifo_drain_baud_gen.sv | 30 +++
 rtl/uart_tx_fifo_drain.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared configuration for the UART TX FIFO drain: bit timing, byte width and frame shape.
// Defining UART_TX_PARITY_EN selects an 8E1 frame; leaving it undefined gives 8N1.
package uart_tx_fifo_drain_pkg;

   localparam int UartClksPerBit = 4;
   localparam int UartDataBits   = 8;

`ifdef UART_TX_PARITY_EN
   localparam bit UartParityEn = 1'b1;
`else
   localparam bit UartParityEn = 1'b0;
`endif

   // Bit periods per frame: start + data + optional parity + stop.
   localparam int UartFrameBits = UartParityEn ? 32'sd11 : 32'sd10;

   function automatic logic even_parity(input logic [UartDataBits-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_baud_gen.sv
// Bit-period timer for the UART transmitter: a down-counter that flags the last
// clock cycle of every bit period and is held at its reload value while restart is high.
module uart_baud_gen #(
   parameter int ClksPerBit = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic restart,
   output logic tick
);

   localparam int              CntW   = $clog2(ClksPerBit);
   localparam logic [CntW-1:0] Reload = CntW'(ClksPerBit - 1);

   logic [CntW-1:0] r_cnt;

   // Count down one bit period, reloading at each bit boundary.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_cnt <= '0;
      end else if (restart || (r_cnt == '0)) begin
         r_cnt <= Reload;
      end else begin
         r_cnt <= r_cnt - CntW'(1);
      end
   end

   assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a byte-wide FIFO read port onto an idle-high serial line.
// Build option UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_fifo_drain
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int ClksPerBit = UartClksPerBit,
   parameter int DataBits   = UartDataBits
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [DataBits-1:0] data_i,
   input  logic                valid_i,
   output logic                ack,
   output logic                tx_o,
   output logic                busy_o
);

   localparam int BitW = $clog2(DataBits);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t              r_state;
   logic [DataBits-1:0] r_shift;
   logic [BitW-1:0]     r_bit_cnt;
   logic                r_ack;
   logic                r_tx;
   logic                r_busy;
`ifdef UART_TX_PARITY_EN
   logic                r_par;
`endif

   logic w_tick;
   logic w_restart;
   logic w_load;

   // The FIFO head is only sampled in IDLE or on the last stop-bit cycle.
   assign w_restart = (r_state == S_IDLE);
   assign w_load    = valid_i && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

   uart_baud_gen #(
      .ClksPerBit (ClksPerBit)
   ) u_baud_gen (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .restart (w_restart),
      .tick    (w_tick)
   );

   // Frame sequencer: owns the line, the ack pulse and the busy flag.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_ack     <= 1'b0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else if (w_load) begin
         r_state   <= S_START;
         r_shift   <= data_i;
         r_bit_cnt <= '0;
         r_ack     <= 1'b1;
         r_tx      <= 1'b0;
         r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par     <= even_parity(data_i);
`endif
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx   <= 1'b1;
               r_busy <= 1'b0;
            end
            S_START: begin
               if (w_tick) begin
                  r_state   <= S_DATA;
                  r_bit_cnt <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_bit_cnt == BitW'(DataBits - 1)) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BitW'(1);
                     r_shift   <= {1'b0, r_shift[DataBits-1:1]};
                     r_tx      <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_tick) begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               // A pending byte at this point was already taken by w_load.
               if (w_tick) begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ack    = r_ack;
   assign tx_o   = r_tx;
   assign busy_o = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: a queue-backed FIFO feeds the DUT and a
// frame-offset reference model predicts ack, tx_o and busy_o every cycle.
module tb_uart_tx_fifo_drain;
   import uart_tx_fifo_drain_pkg::*;

   localparam int C           = 4;
   localparam int FrameCycles = UartFrameBits * C;

   logic       clk     = 1'b0;
   logic       reset_i = 1'b0;
   logic       valid_i = 1'b0;
   logic [7:0] data_i  = 8'h00;
   logic       ack;
   logic       tx_o;
   logic       busy_o;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] fifo_q[$];
   int         ack_cycles[$];

   bit         m_active  = 1'b0;
   int         m_k       = 0;
   logic [7:0] m_byte    = 8'h00;
   int         last_ack  = 0;
   logic       prev_busy = 1'b0;

   always #5 clk = ~clk;

   uart_tx_fifo_drain #(
      .ClksPerBit (C),
      .DataBits   (8)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .ack     (ack),
      .tx_o    (tx_o),
      .busy_o  (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Line level k cycles into a frame carrying byte b.
   function automatic logic exp_line(input logic [7:0] b, input int k);
      int idx;
      idx = k / C;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (UartParityEn && idx == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic step(input bit rst_v, input bit gate);
      bit         v;
      logic [7:0] d;
      bit         e_ack;
      @(negedge clk);
      reset_i = rst_v;
      v       = gate && (fifo_q.size() > 0);
      d       = v ? fifo_q[0] : 8'($urandom);
      valid_i = v;
      data_i  = d;
      @(posedge clk);
      #1;
      cyc++;
      e_ack = 1'b0;
      if (!rst_v) begin
         m_active = 1'b0;
      end else if (m_active && m_k != FrameCycles - 1) begin
         m_k++;
      end else if (v) begin
         m_active = 1'b1;
         m_k      = 0;
         m_byte   = d;
         e_ack    = 1'b1;
      end else begin
         m_active = 1'b0;
      end
      check("ack", 32'(ack), 32'(e_ack));
      check("tx", 32'(tx_o), 32'(m_active ? exp_line(m_byte, m_k) : 1'b1));
      check("busy", 32'(busy_o), 32'(m_active));
      if (ack === 1'b1) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         ack_cycles.push_back(cyc);
         last_ack = cyc;
      end
      if (prev_busy && busy_o === 1'b0 && rst_v) check("busy_len", 32'(cyc - last_ack), 32'(FrameCycles));
      prev_busy = busy_o;
   endtask

   initial begin
      // Reset held with a byte waiting, then that byte (0xEF) goes out alone.
      fifo_q.push_back(8'hEF);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      ack_cycles.delete();
      for (int i = 0; i < FrameCycles + 10; i++) step(1'b1, 1'b1);
      check("single_acks", 32'(ack_cycles.size()), 32'd1);

      // Drain 0xDEADBEEF byte by byte with valid held high.
      ack_cycles.delete();
      fifo_q.push_back(8'hEF);
      fifo_q.push_back(8'hBE);
      fifo_q.push_back(8'hAD);
      fifo_q.push_back(8'hDE);
      for (int i = 0; i < 4 * FrameCycles + 10; i++) step(1'b1, 1'b1);
      check("drain_acks", 32'(ack_cycles.size()), 32'd4);
      for (int i = 1; i < ack_cycles.size(); i++)
         check("drain_spacing", 32'(ack_cycles[i] - ack_cycles[i-1]), 32'(FrameCycles));

      // Reset in the middle of 0x12, then 0x34 goes out cleanly.
      ack_cycles.delete();
      fifo_q.push_back(8'h12);
      for (int i = 0; i < 10 && ack_cycles.size() == 0; i++) step(1'b1, 1'b1);
      check("abort_ack_seen", 32'(ack_cycles.size()), 32'd1);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      check("abort_tx_idle", 32'(tx_o), 32'd1);
      fifo_q.push_back(8'h34);
      for (int i = 0; i < FrameCycles + 10; i++) step(1'b1, 1'b1);
      check("abort_acks", 32'(ack_cycles.size()), 32'd2);

      // valid_i toggles while 0x78 is in flight; the next byte waits for the frame end.
      ack_cycles.delete();
      fifo_q.push_back(8'h78);
      for (int i = 0; i < 10 && ack_cycles.size() == 0; i++) step(1'b1, 1'b1);
      fifo_q.push_back(8'h55);
      for (int i = 0; i < 20; i++) step(1'b1, bit'(i % 2));
      check("toggle_acks_mid", 32'(ack_cycles.size()), 32'd1);
      for (int i = 0; i < 2 * FrameCycles; i++) step(1'b1, 1'b1);
      check("toggle_acks", 32'(ack_cycles.size()), 32'd2);
      if (ack_cycles.size() == 2)
         check("toggle_spacing", 32'(ack_cycles[1] - ack_cycles[0]), 32'(FrameCycles));

      // Random traffic with flickering valid and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if (fifo_q.size() < 4 && $urandom_range(0, 7) == 0) fifo_q.push_back(8'($urandom));
         step(bit'($urandom_range(0, 199) != 0), bit'($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
